// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Load/store unit in front of a byte-addressed RAM. Accepts one
//               CPU request at a time and turns it into one or two
//               word-aligned RAM beats with byte strobes. Accesses that
//               straddle a word boundary take two beats; load data is merged,
//               shifted and sign/zero-extended. Out-of-range or illegal-size
//               requests fault without any RAM activity.
//
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               req_*             - CPU request (valid/ready handshake)
//               resp_*            - one-cycle response pulse, data and fault
//               mem_*             - word-aligned RAM beat (addr/wen/strb/data)
//               mem_rdata         - combinational RAM read data for mem_addr
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int unsigned BYTES = 32'd16000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_wen,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_beat0 = 2'd1;
    localparam logic [1:0]  c_st_beat1 = 2'd2;
    localparam logic [1:0]  c_st_resp  = 2'd3;

    localparam logic [32:0] c_bytes    = 33'(BYTES);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_cross;
    logic        r_fault;
    logic [31:0] r_lo;
    logic [31:0] r_rdata;

    // ------------------------------------------------------------------
    // Request decode (used only at acceptance in IDLE)
    // ------------------------------------------------------------------
    logic [2:0]  w_req_nbytes;
    logic [32:0] w_req_last;
    logic        w_req_fault;
    logic        w_req_cross;

    always_comb begin
        case (req_size)
            2'd0:    w_req_nbytes = 3'd1;
            2'd1:    w_req_nbytes = 3'd2;
            default: w_req_nbytes = 3'd4;
        endcase
    end

    // Last byte touched, in 33 bits so an access near 2^32 cannot wrap and
    // slip under the bound.
    assign w_req_last  = {1'b0, req_addr} + {30'd0, w_req_nbytes} - 33'd1;
    assign w_req_fault = (req_size == 2'd3) || (w_req_last >= c_bytes);
    // off + n fits in 3 bits (max 3 + 4 = 7)
    assign w_req_cross = ({1'b0, req_addr[1:0]} + w_req_nbytes) > 3'd4;

    // ------------------------------------------------------------------
    // Beat data from the latched request
    // ------------------------------------------------------------------
    logic [3:0]  w_mask4;
    logic [7:0]  w_sm;
    logic [63:0] w_sd;
    logic [31:0] w_base;
    logic [4:0]  w_shamt;

    always_comb begin
        case (r_size)
            2'd0:    w_mask4 = 4'h1;
            2'd1:    w_mask4 = 4'h3;
            default: w_mask4 = 4'hF;
        endcase
    end

    assign w_shamt = {r_addr[1:0], 3'b000};
    assign w_sm    = {4'h0, w_mask4} << r_addr[1:0];
    assign w_sd    = {32'd0, r_wdata} << w_shamt;
    assign w_base  = {r_addr[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Load merge: in BEAT0 the low word is live on mem_rdata; in BEAT1 the
    // low word comes from r_lo and the high word is live.
    // ------------------------------------------------------------------
    logic [31:0] w_lo_src;
    logic [31:0] w_hi_src;
    logic [63:0] w_merged;
    logic [31:0] w_raw;
    logic [31:0] w_ext;
    logic        w_load_done;

    assign w_lo_src = (r_state == c_st_beat1) ? r_lo : mem_rdata;
    assign w_hi_src = (r_state == c_st_beat1) ? mem_rdata : 32'd0;
    assign w_merged = {w_hi_src, w_lo_src} >> w_shamt;
    assign w_raw    = w_merged[31:0];

    always_comb begin
        case (r_size)
            2'd0:    w_ext = r_unsigned ? {24'd0, w_raw[7:0]}
                                        : {{24{w_raw[7]}}, w_raw[7:0]};
            2'd1:    w_ext = r_unsigned ? {16'd0, w_raw[15:0]}
                                        : {{16{w_raw[15]}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    assign w_load_done = !r_we &&
                         (((r_state == c_st_beat0) && !r_cross) ||
                          (r_state == c_st_beat1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch, load capture and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_cross    <= 1'b0;
            r_fault    <= 1'b0;
            r_lo       <= 32'd0;
            r_rdata    <= 32'd0;
        end else begin
            if ((r_state == c_st_idle) && req_valid) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_cross    <= w_req_cross;
                r_fault    <= w_req_fault;
                // Stores and faults respond with zero data.
                r_rdata    <= 32'd0;
            end
            if (r_state == c_st_beat0) begin
                r_lo <= mem_rdata;
            end
            if (w_load_done) begin
                r_rdata <= w_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs; all outputs decode from registered state,
    // so nothing on req_* reaches mem_* combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'd0;
        resp_fault  = 1'b0;
        mem_wen     = 1'b0;
        mem_wstrb   = 4'h0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;

        case (r_state)
            c_st_idle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_req_fault ? c_st_resp : c_st_beat0;
                end
            end

            c_st_beat0: begin
                mem_addr = w_base;
                if (r_we) begin
                    mem_wen   = 1'b1;
                    mem_wstrb = w_sm[3:0];
                    mem_wdata = w_sd[31:0];
                end
                w_state_nxt = r_cross ? c_st_beat1 : c_st_resp;
            end

            c_st_beat1: begin
                mem_addr = w_base + 32'd4;
                if (r_we) begin
                    mem_wen   = 1'b1;
                    mem_wstrb = w_sm[7:4];
                    mem_wdata = w_sd[63:32];
                end
                w_state_nxt = c_st_resp;
            end

            c_st_resp: begin
                resp_valid  = 1'b1;
                resp_rdata  = r_rdata;
                resp_fault  = r_fault;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu. A word-organised RAM is
//               attached to the memory port; a byte-level reference memory
//               predicts load data, faults, latency and beat counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    localparam int unsigned BYTES = 32'd16000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_lsu #(.BYTES(BYTES)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_wen      (mem_wen),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- RAM attached to the DUT (word organised) ----------
    logic [31:0] ram [int unsigned];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        int unsigned k = int'(a >> 2);
        if (ram.exists(k)) return ram[k];
        return 32'h0;
    endfunction

    // Read data refreshed mid-cycle: address is stable by then and the
    // previous edge's write has landed.
    always @(negedge clk) mem_rdata = ram_rd(mem_addr);

    always @(posedge clk) begin : ram_write
        logic [31:0] w;
        if (mem_wen) begin
            w = ram_rd(mem_addr);
            for (int i = 0; i < 4; i++)
                if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            ram[int'(mem_addr >> 2)] = w;
        end
    end

    // ---------------- Byte-level reference model ------------------------
    bit [7:0] ref_mem [int unsigned];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_fault(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 1'b1;
        return (longint'(a) + longint'(nbytes(s)) - 1) >= longint'(BYTES);
    endfunction

    function automatic bit ref_cross(input logic [1:0] s, input logic [31:0] a);
        return (int'(a % 4) + nbytes(s)) > 4;
    endfunction

    function automatic int ref_latency(input logic [1:0] s, input logic [31:0] a);
        if (ref_fault(s, a)) return 1;
        return ref_cross(s, a) ? 3 : 2;
    endfunction

    // Writes the first 'limit' bytes of the access (limit >= n means all).
    task automatic ref_store(input logic [31:0] a, input logic [1:0] s,
                             input logic [31:0] d, input int limit);
        for (int i = 0; i < nbytes(s) && i < limit; i++)
            ref_mem[int'(a + i)] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input logic [1:0] s,
                                             input logic uns);
        longint unsigned v = 0;
        int n = nbytes(s);
        for (int i = 0; i < n; i++) begin
            int unsigned k = int'(a + i);
            if (ref_mem.exists(k)) v = v | (longint'(ref_mem[k]) << (8 * i));
        end
        if (!uns && n < 4 && (((v >> (8 * n - 1)) & 1) == 1))
            v = v | ~((64'd1 << (8 * n)) - 1);
        return v[31:0];
    endfunction

    // ---------------- Transaction driver (observes, does not judge) -----
    logic [31:0] got_rdata;
    logic        got_fault;
    logic        got_ready_in;     // req_ready before accept
    logic        got_ready_resp;   // req_ready during the response cycle
    logic        got_valid_after;  // resp_valid one cycle after response
    int          got_lat;
    int          got_writes;
    logic [31:0] b_addr [$];
    logic [3:0]  b_strb [$];
    logic [31:0] b_wdata [$];

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        b_addr.delete(); b_strb.delete(); b_wdata.delete();
        got_lat = 0; got_writes = 0; got_rdata = 'x; got_fault = 'x;
        got_ready_resp = 'x; got_valid_after = 'x;
        @(negedge clk);
        got_ready_in = req_ready;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        for (int c = 1; c <= 6; c++) begin
            if (resp_valid === 1'b1) begin
                req_valid = 1'b0;
                got_lat = c; got_rdata = resp_rdata; got_fault = resp_fault;
                got_ready_resp = req_ready;
                break;
            end
            // A competing store while busy must be ignored entirely.
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
            req_addr = 32'h0000_0F00; req_wdata = 32'h5A5A_5A5A;
            b_addr.push_back(mem_addr); b_strb.push_back(mem_wstrb);
            b_wdata.push_back(mem_wdata);
            if (mem_wen === 1'b1) got_writes++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (got_lat != 0) begin
            @(posedge clk); #1;
            got_valid_after = resp_valid;
        end
    endtask

    // ---------------- Tests ---------------------------------------------
    task automatic test_reset();
        #12;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if ({resp_valid, resp_fault, resp_rdata} !== 34'd0) begin errors++; $display("FAIL reset_resp: got v=%b f=%b d=%h expected all 0", resp_valid, resp_fault, resp_rdata); end
        checks++; if ({mem_wen, mem_wstrb, mem_addr, mem_wdata} !== 69'd0) begin errors++; $display("FAIL reset_mem: got wen=%b strb=%h addr=%h wdata=%h expected all 0", mem_wen, mem_wstrb, mem_addr, mem_wdata); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL reset_release: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_aligned_word();
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        ref_store(32'h100, 2'd2, 32'hDEADBEEF, 4);
        checks++; if (got_ready_in !== 1'b1) begin errors++; $display("FAIL aw_ready_idle: got %b expected 1", got_ready_in); end
        checks++; if (got_lat != 2) begin errors++; $display("FAIL aw_store_lat: got %0d expected 2", got_lat); end
        checks++; if (b_addr.size() != 1 || b_addr[0] !== 32'h100 || b_strb[0] !== 4'hF || b_wdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL aw_store_beat: got n=%0d addr=%h strb=%h data=%h expected 1/100/f/deadbeef", b_addr.size(), b_addr[0], b_strb[0], b_wdata[0]); end
        checks++; if (got_fault !== 1'b0 || got_rdata !== 32'h0) begin errors++; $display("FAIL aw_store_resp: got f=%b d=%h expected 0/0", got_fault, got_rdata); end
        checks++; if (got_ready_resp !== 1'b0 || got_valid_after !== 1'b0) begin errors++; $display("FAIL aw_resp_pulse: got ready=%b next_valid=%b expected 0/0", got_ready_resp, got_valid_after); end
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        checks++; if (got_lat != 2) begin errors++; $display("FAIL aw_load_lat: got %0d expected 2", got_lat); end
        checks++; if (got_rdata !== ref_load(32'h100, 2'd2, 1'b0) || got_writes != 0) begin errors++; $display("FAIL aw_load_data: got %h writes=%0d expected %h writes=0", got_rdata, got_writes, ref_load(32'h100, 2'd2, 1'b0)); end
    endtask

    task automatic test_byte_ext();
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h000080FF);
        ref_store(32'h100, 2'd2, 32'h000080FF, 4);
        do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
        checks++; if (got_rdata !== ref_load(32'h101, 2'd0, 1'b0) || got_lat != 2 || b_addr.size() != 1) begin errors++; $display("FAIL byte_signed: got %h lat=%0d beats=%0d expected %h lat=2 beats=1", got_rdata, got_lat, b_addr.size(), ref_load(32'h101, 2'd0, 1'b0)); end
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        checks++; if (got_rdata !== ref_load(32'h101, 2'd0, 1'b1) || got_lat != 2) begin errors++; $display("FAIL byte_unsigned: got %h lat=%0d expected %h lat=2", got_rdata, got_lat, ref_load(32'h101, 2'd0, 1'b1)); end
    endtask

    task automatic test_cross_word();
        do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344);
        ref_store(32'h102, 2'd2, 32'h11223344, 4);
        checks++; if (got_lat != 3 || b_addr.size() != 2) begin errors++; $display("FAIL cw_store_lat: got lat=%0d beats=%0d expected 3/2", got_lat, b_addr.size()); end
        else begin
            checks++; if (b_addr[0] !== 32'h100 || b_strb[0] !== 4'hC || b_wdata[0] !== 32'h33440000) begin errors++; $display("FAIL cw_beat0: got addr=%h strb=%h data=%h expected 100/c/33440000", b_addr[0], b_strb[0], b_wdata[0]); end
            checks++; if (b_addr[1] !== 32'h104 || b_strb[1] !== 4'h3 || b_wdata[1] !== 32'h00001122) begin errors++; $display("FAIL cw_beat1: got addr=%h strb=%h data=%h expected 104/3/00001122", b_addr[1], b_strb[1], b_wdata[1]); end
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
        checks++; if (got_rdata !== ref_load(32'h102, 2'd2, 1'b0) || got_lat != 3) begin errors++; $display("FAIL cw_load: got %h lat=%0d expected %h lat=3", got_rdata, got_lat, ref_load(32'h102, 2'd2, 1'b0)); end
    endtask

    task automatic test_cross_half();
        do_req(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000A5A5);
        ref_store(32'h103, 2'd1, 32'h0000A5A5, 4);
        checks++; if (b_strb.size() != 2 || b_strb[0] !== 4'h8 || b_strb[1] !== 4'h1 || got_writes != 2) begin errors++; $display("FAIL ch_strobes: got n=%0d s0=%h s1=%h writes=%0d expected 2/8/1/2", b_strb.size(), b_strb[0], b_strb[1], got_writes); end
        do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
        checks++; if (got_rdata !== ref_load(32'h103, 2'd1, 1'b0) || got_lat != 3) begin errors++; $display("FAIL ch_load: got %h lat=%0d expected %h lat=3", got_rdata, got_lat, ref_load(32'h103, 2'd1, 1'b0)); end
    endtask

    task automatic test_faults();
        do_req(1'b0, 2'd2, 1'b0, BYTES - 3, 32'h0);
        checks++; if (got_fault !== 1'b1 || got_lat != 1 || got_rdata !== 32'h0 || b_addr.size() != 0) begin errors++; $display("FAIL f_word_top: got f=%b lat=%0d d=%h beats=%0d expected 1/1/0/0", got_fault, got_lat, got_rdata, b_addr.size()); end
        do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF);
        checks++; if (got_fault !== 1'b1 || got_lat != 1 || got_rdata !== 32'h0 || got_writes != 0) begin errors++; $display("FAIL f_size3: got f=%b lat=%0d d=%h writes=%0d expected 1/1/0/0", got_fault, got_lat, got_rdata, got_writes); end
        do_req(1'b0, 2'd2, 1'b0, BYTES - 4, 32'h0);
        checks++; if (got_fault !== 1'b0 || got_lat != 2 || got_rdata !== ref_load(BYTES - 4, 2'd2, 1'b0)) begin errors++; $display("FAIL f_word_last_ok: got f=%b lat=%0d d=%h expected 0/2/%h", got_fault, got_lat, got_rdata, ref_load(BYTES - 4, 2'd2, 1'b0)); end
        do_req(1'b1, 2'd1, 1'b0, BYTES - 1, 32'h1234);
        checks++; if (got_fault !== 1'b1 || got_writes != 0) begin errors++; $display("FAIL f_half_store: got f=%b writes=%0d expected 1/0", got_fault, got_writes); end
    endtask

    task automatic test_reset_mid_beat();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h206; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;   // BEAT1; beat 0 (bytes 0x206..0x207) is now in RAM
        checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h208) begin errors++; $display("FAIL rm_in_beat1: got wen=%b addr=%h expected 1/208", mem_wen, mem_addr); end
        ref_store(32'h206, 2'd2, 32'hCAFEF00D, 2);
        #2 reset = 1'b1;
        #1;
        checks++; if ({mem_wen, mem_wstrb, mem_addr, mem_wdata} !== 69'd0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_async: got wen=%b strb=%h addr=%h valid=%b ready=%b expected zeros, ready 1", mem_wen, mem_wstrb, mem_addr, resp_valid, req_ready); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_resp: got %b expected 0", resp_valid); end
        end
        @(negedge clk); reset = 1'b0;
        do_req(1'b0, 2'd2, 1'b1, 32'h204, 32'h0);
        checks++; if (got_ready_in !== 1'b1 || got_lat != 2 || got_rdata !== ref_load(32'h204, 2'd2, 1'b1)) begin errors++; $display("FAIL rm_after: got ready=%b lat=%0d d=%h expected 1/2/%h", got_ready_in, got_lat, got_rdata, ref_load(32'h204, 2'd2, 1'b1)); end
        do_req(1'b0, 2'd2, 1'b0, 32'h208, 32'h0);
        checks++; if (got_rdata !== ref_load(32'h208, 2'd2, 1'b0)) begin errors++; $display("FAIL rm_beat1_unwritten: got %h expected %h", got_rdata, ref_load(32'h208, 2'd2, 1'b0)); end
    endtask

    task automatic test_random();
        logic        we, uns, flt;
        logic [1:0]  sz;
        logic [31:0] a, d, exp_d;
        int          r, exp_w;
        for (int it = 0; it < 300; it++) begin
            r  = $urandom_range(0, 9);
            sz = (r == 9) ? 2'd3 : 2'(r % 3);
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            d  = $urandom;
            a  = ($urandom_range(0, 3) == 0) ? (BYTES - 8 + $urandom_range(0, 11))
                                             : (32'h400 + $urandom_range(0, 63));
            flt   = ref_fault(sz, a);
            exp_d = (!we && !flt) ? ref_load(a, sz, uns) : 32'h0;
            exp_w = (we && !flt) ? (ref_cross(sz, a) ? 2 : 1) : 0;
            do_req(we, sz, uns, a, d);
            checks++; if (got_fault !== flt || got_rdata !== exp_d || got_lat != ref_latency(sz, a) || got_writes != exp_w) begin
                errors++;
                $display("FAIL rand_%0d we=%b sz=%0d a=%h: got f=%b d=%h lat=%0d wr=%0d expected f=%b d=%h lat=%0d wr=%0d", it, we, sz, a, got_fault, got_rdata, got_lat, got_writes, flt, exp_d, ref_latency(sz, a), exp_w);
            end
            foreach (b_addr[i]) begin
                checks++; if (b_addr[i][1:0] !== 2'b00) begin errors++; $display("FAIL rand_align_%0d: got addr %h expected multiple of 4", it, b_addr[i]); end
            end
            if (we && !flt) ref_store(a, sz, d, 4);
        end
    endtask

    task automatic test_final_mem();
        logic [31:0] w;
        foreach (ref_mem[k]) begin
            w = ram_rd(k);
            checks++; if (w[8*(k%4) +: 8] !== ref_mem[k]) begin errors++; $display("FAIL mem_byte_%h: got %h expected %h", k, w[8*(k%4) +: 8], ref_mem[k]); end
        end
        checks++; if (ram_rd(32'h0000_0F00) !== 32'h0) begin errors++; $display("FAIL busy_req_ignored: got %h expected 0", ram_rd(32'h0000_0F00)); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_aligned_word();
        test_byte_ext();
        test_cross_word();
        test_cross_half();
        test_faults();
        test_reset_mid_beat();
        test_random();
        test_final_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit sitting directly upstream of the byte-addressed RAM: it accepts one CPU memory request at a time and converts it into word-aligned RAM beats with byte strobes. Accesses that cross a word boundary are split into two beats; load data is merged, shifted and sign/zero-extended. Out-of-range or illegal-size requests fault without touching memory. System policy: every RAM address this block drives is word-aligned.

Parameters:
BYTES, 16000000, RAM size in bytes; highest legal byte address is BYTES-1

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-justified
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  qualified by resp_valid; range or size fault
mem_wen  output  1  RAM write enable
mem_wstrb  output  4  RAM byte strobes
mem_addr  output  32  RAM byte address, always multiple of 4
mem_wdata  output  32  RAM write data
mem_rdata  input  32  RAM combinational read data for mem_addr

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_fault=0; mem_wen=0, mem_wstrb=0, mem_addr=0, mem_wdata=0; in-flight request discarded, no response.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid: latch we/size/unsigned/addr/wdata; off=addr[1:0]; n=1/2/4 bytes; mask=(1<<n)-1.
  - size==3, or addr+n-1 >= BYTES (32-bit unsigned compare, with addr+n-1 computed in 33 bits) -> RESP with fault=1.
  - else -> BEAT0. cross = (off+n > 4).
- BEAT0: mem_addr={addr[31:2],2'b00}; sm=mask<<off (8 bits), sd=wdata<<(8*off) (64 bits).
  - Store: mem_wen=1, mem_wstrb=sm[3:0], mem_wdata=sd[31:0].
  - Load: mem_wen=0, mem_wstrb=0; capture lo=mem_rdata at clock edge.
  - cross ? BEAT1 : RESP.
- BEAT1: mem_addr=BEAT0 address+4.
  - Store: mem_wen=1, mem_wstrb=sm[7:4], mem_wdata=sd[63:32].
  - Load: capture hi=mem_rdata.
  - -> RESP.
- Outside BEAT0/BEAT1: mem_wen=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
- Load merge: raw={hi,lo}>>(8*off), take low 8*n bits; extend to 32 per req_unsigned (ignored for word).
- RESP: resp_valid=1 for exactly one cycle with rdata/fault; req_ready=0; -> IDLE.
- Latency, request accepted at edge k:
  - aligned / non-crossing: resp_valid high in cycle k+2.
  - crossing: cycle k+3.
  - fault: cycle k+1.
- Throughput: one request in flight; req_valid ignored while req_ready=0.
- Non-crossing misaligned (half at off=1, byte anywhere) is a single beat.
- Stores never write bytes outside the mask; faulting stores write nothing.
- Address bound uses the byte range touched, not the aligned word: word load at BYTES-4 is legal; at BYTES-3 faults.
- Outputs registered or decoded from state only; no combinational path from req_* to mem_*.

Test Plan:
- Aligned word store 0xDEADBEEF to 0x100, then load word 0x100 -> BEAT0 mem_wstrb=4'hF, mem_addr=0x100; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Byte load from 0x101, RAM word 0x000080FF at 0x100: signed -> 0xFFFFFF80; unsigned -> 0x00000080; single beat each.
- Crossing word store 0x11223344 to 0x102 -> beat0 addr 0x100, wstrb 4'hC, wdata 0x33440000; beat1 addr 0x104, wstrb 4'h3, wdata 0x00001122. Load back 0x102 -> 0x11223344, resp 3 cycles after accept.
- Half store 0xA5A5 to 0x103 -> two beats: strobes 4'h8 then 4'h1. Signed half load from 0x103 -> 0xFFFFA5A5.
- Word load at BYTES-3; req_size=3 at 0x0 -> resp_fault=1 one cycle after accept, resp_rdata=0, mem_wen never asserted.
- Assert reset during BEAT1 of a crossing store -> outputs zero immediately, no resp_valid; req_ready=1 after reset release; next request completes normally.
